// File: rtl/qracc_stat_counters.sv
// ---------------------------------------------------------------------------
// qracc_pkg / qracc_stat_counters
//
// Purpose: a bank of NUM_CNT event counters behind a simple request/response
// register window. Live counters accumulate per-cycle increments (saturating
// or wrapping), and software reads a coherent copy of them through snapshot
// registers taken on command.
//
// Ports:
//   clk          in   sole clock, rising edge
//   nrst         in   asynchronous active-low reset
//   event_inc_i  in   NUM_CNT*INC_W, unsigned increment for counter i in
//                     slice [i*INC_W +: INC_W]
//   bus_req_i    in   bus_req_t  {data_in, addr, wen, valid}
//   bus_resp_o   out  bus_resp_t {ready, data_out, rd_data_valid}
//   overflow_o   out  NUM_CNT sticky overflow flags
//
// Register map (byte offset from BASE_ADDR, addr[1:0] ignored):
//   0x00        CTRL  bit0 enable, bit1 clear (W1), bit2 snapshot (W1),
//                     bit3 sat_mode (1 saturate, 0 wrap)
//   0x04        OVF   overflow flags, write-1-to-clear
//   0x10+8*i    snapshot i [31:0]
//   0x14+8*i    snapshot i [CNT_W-1:32], zero-extended
// ---------------------------------------------------------------------------
package qracc_pkg;
    typedef struct packed {
        logic [31:0] data_in;
        logic [31:0] addr;
        logic        wen;
        logic        valid;
    } bus_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data_out;
        logic        rd_data_valid;
    } bus_resp_t;
endpackage

module qracc_stat_counters
    import qracc_pkg::*;
#(
    parameter int          NUM_CNT   = 11,
    parameter int          CNT_W     = 32,
    parameter int          INC_W     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_CNT*INC_W-1:0] event_inc_i,
    input  bus_req_t                 bus_req_i,
    output bus_resp_t                bus_resp_o,
    output logic [NUM_CNT-1:0]       overflow_o
);

    // One spare bit above the wider operand holds any amount of overflow.
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t             r_state;
    logic               r_enable;
    logic               r_sat_mode;
    logic [CNT_W-1:0]   r_cnt  [NUM_CNT];
    logic [CNT_W-1:0]   r_snap [NUM_CNT];
    logic [NUM_CNT-1:0] r_ovf;
    logic [31:0]        r_rdata;
    logic               r_rvalid;

    logic               w_accept;
    logic               w_wr;
    logic [29:0]        w_word;
    logic               w_ctrl_wr;
    logic               w_ovf_wr;
    logic               w_clear;
    logic               w_snap;
    logic [NUM_CNT-1:0] w_ovf_set;
    logic [NUM_CNT-1:0] w_ovf_clr;
    logic [SUM_W-1:0]   w_sum     [NUM_CNT];
    logic [CNT_W-1:0]   w_cnt_nxt [NUM_CNT];
    logic [63:0]        w_snap64  [NUM_CNT];
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_accept  = bus_req_i.valid && (r_state == S_IDLE);
    assign w_wr      = w_accept && bus_req_i.wen;
    // Word-granular offset; the byte lane bits never take part in decode.
    assign w_word    = bus_req_i.addr[31:2] - BASE_ADDR[31:2];
    assign w_ctrl_wr = w_wr && (w_word == 30'd0);
    assign w_ovf_wr  = w_wr && (w_word == 30'd1);
    assign w_clear   = w_ctrl_wr && bus_req_i.data_in[1];
    assign w_snap    = w_ctrl_wr && bus_req_i.data_in[2];
    assign w_ovf_clr = w_ovf_wr ? bus_req_i.data_in[NUM_CNT-1:0] : '0;
    assign w_unused  = ^{bus_req_i.data_in, bus_req_i.addr[1:0]};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign w_sum[g] = SUM_W'(r_cnt[g]) + SUM_W'(event_inc_i[g*INC_W +: INC_W]);
        // A clear drops this cycle's increment, so it cannot raise a flag either.
        assign w_ovf_set[g] = r_enable && !w_clear && (|w_sum[g][SUM_W-1:CNT_W]);
        assign w_cnt_nxt[g] = (r_sat_mode && (|w_sum[g][SUM_W-1:CNT_W])) ?
                              {CNT_W{1'b1}} : w_sum[g][CNT_W-1:0];
        assign w_snap64[g]  = 64'(r_snap[g]);
    end

    always_comb begin
        w_rdata = '0;
        if (w_word == 30'd0) begin
            w_rdata = {28'd0, r_sat_mode, 2'b00, r_enable};
        end else if (w_word == 30'd1) begin
            w_rdata = 32'(r_ovf);
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_word == 30'(4 + 2*i)) w_rdata = w_snap64[i][31:0];
            if (w_word == 30'(5 + 2*i)) w_rdata = w_snap64[i][63:32];
        end
    end

    // Control and sticky flags; a new overflow wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_enable   <= 1'b0;
            r_sat_mode <= 1'b1;
            r_ovf      <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable   <= bus_req_i.data_in[0];
                r_sat_mode <= bus_req_i.data_in[3];
            end
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
        end
    end

    // Snapshots take the value held before this edge, so a combined
    // clear+snapshot captures pre-clear counts.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_snap) r_snap[i] <= r_cnt[i];
                if (w_clear) begin
                    r_cnt[i] <= '0;
                end else if (r_enable) begin
                    r_cnt[i] <= w_cnt_nxt[i];
                end
            end
        end
    end

    // Bus FSM: one response cycle after every accepted request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RESP;
                        if (!bus_req_i.wen) begin
                            r_rdata  <= w_rdata;
                            r_rvalid <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign bus_resp_o = {(r_state == S_IDLE), r_rdata, r_rvalid};
    assign overflow_o = r_ovf;

endmodule

// File: doc/qracc_stat_counters.md
QRACC_STAT_COUNTERS -- requirements
Module: qracc_stat_counters

Interface
REQ-001 SHALL have parameter NUM_CNT, default 11, meaning number of event counters (1..32).
REQ-002 SHALL have parameter CNT_W, default 32, meaning counter width in bits (1..64).
REQ-003 SHALL have parameter INC_W, default 4, meaning per-counter per-cycle increment width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0100, meaning byte base address of the register window.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port event_inc_i  input  NUM_CNT*INC_W  unsigned increment for counter i in slice [i*INC_W +: INC_W].
REQ-008 SHALL have port bus_req_i  input  66 (qracc_pkg::bus_req_t)  data_in, addr, wen, valid.
REQ-009 SHALL have port bus_resp_o  output  34 (qracc_pkg::bus_resp_t)  ready, data_out, rd_data_valid.
REQ-010 SHALL have port overflow_o  output  NUM_CNT  sticky overflow flags.

Function
REQ-011 SHALL decode byte offset = addr - BASE_ADDR; addr[1:0] ignored.
REQ-012 SHALL map 0x00 CTRL: bit0 enable (RW), bit1 clear (W1, self-clearing), bit2 snapshot (W1, self-clearing), bit3 sat_mode (RW; 1 saturate, 0 wrap).
REQ-013 SHALL map 0x04 OVF: overflow flags, write-1-to-clear, upper bits read 0.
REQ-014 SHALL map 0x10+8*i snapshot i bits [31:0], 0x14+8*i bits [CNT_W-1:32] zero-extended (reads 0 when CNT_W<=32).
REQ-015 SHALL return 0 for reads of unmapped offsets, and ignore writes to unmapped or read-only offsets.
REQ-016 SHALL implement bus FSM states S_IDLE and S_RESP; ready=1 only in S_IDLE.
REQ-017 SHALL accept a request when valid && ready in S_IDLE, then move to S_RESP for exactly one cycle and return to S_IDLE.
REQ-018 SHALL, for an accepted read, drive data_out and rd_data_valid=1 in the S_RESP cycle only; data_out=0 otherwise.
REQ-019 SHALL, for an accepted write, update registers at the accepting edge and keep rd_data_valid=0.
REQ-020 SHALL ignore valid while ready=0 (master must hold until accepted).
REQ-021 SHALL, each cycle with enable=1, add zero-extended event_inc_i slice to live counter i.
REQ-022 SHALL, in sat_mode=1, clamp at 2^CNT_W-1 and set overflow[i] when the true sum exceeds it.
REQ-023 SHALL, in sat_mode=0, wrap modulo 2^CNT_W and set overflow[i] on carry-out.
REQ-024 SHALL hold counters when enable=0.
REQ-025 SHALL serve reads from snapshot registers only, never live counters.
REQ-026 SHALL, on snapshot, copy all live counters into snapshots at the write edge, capturing pre-increment values of that cycle.
REQ-027 SHALL, on clear, zero all live counters and drop that cycle's increments; snapshots and flags unchanged.
REQ-028 SHALL, on clear and snapshot in one write, capture pre-clear values then clear.
REQ-029 SHALL let overflow set win over a simultaneous W1C of the same bit.

Reset
REQ-030 SHALL, while nrst=0, force counters, snapshots, overflow_o, data_out, rd_data_valid to 0, enable=0, sat_mode=1, FSM=S_IDLE, ready=1.
REQ-031 SHALL abort any in-flight response on reset without emitting rd_data_valid.

Verification
REQ-032 SHALL cover: write CTRL=0x9, inc0=3 for 10 cycles, write CTRL=0xD, read 0x10 -> data_out=30 with rd_data_valid one cycle after accept, ready low that cycle.
REQ-033 SHALL cover: CNT_W=8, sat_mode=1, inc0=15 for 20 cycles -> snapshot0=255, overflow_o[0]=1; write OVF=1 -> flag 0.
REQ-034 SHALL cover: CNT_W=8, sat_mode=0, counter at 250, inc0=10 one cycle -> live value 4, overflow_o[0]=1.
REQ-035 SHALL cover: counter1=100, write CTRL=0xF with inc1=5 same cycle -> snapshot1=100, live counter1=0 next cycle.
REQ-036 SHALL cover: read unmapped offset 0x08 -> data_out=0, rd_data_valid=1; nrst pulsed during S_RESP -> rd_data_valid stays 0, ready=1.
REQ-037 SHALL cover: CNT_W=40, counter at 2^32+7, snapshot, read 0x10 then 0x14 -> 7 then 1.
